// File: rtl/cmp_seq16.sv
// Sequential magnitude comparator: walks two 4*NIB-bit operands LSB nibble first
// through an external cascaded 4-bit comparator and reports a one-hot verdict.
module cmp_seq16 #(
    parameter int NIB = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [4*NIB-1:0] iOpA,
    input  logic [4*NIB-1:0] iOpB,
    output logic             oValid,
    input  logic             iReady,
    output logic [2:0]       oResult,
    output logic             oErr,
    output logic [3:0]       oCmpA,
    output logic [3:0]       oCmpB,
    output logic [2:0]       oCmpCas,
    input  logic [2:0]       iCmpRes,
    output logic             oBusy
);

    localparam int          W      = 4 * NIB;
    localparam int          IW     = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [2:0]  CAS_EQ = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2:0]      cas_q, cas_d;
    logic            err_q, err_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cas_q   <= CAS_EQ;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cas_q   <= cas_d;
            err_q   <= err_d;
        end
    end

    // Operands are pure data: only ever meaningful after a capture in IDLE.
    always_ff @(posedge iClk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cas_d   = cas_q;
        err_d   = err_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        oReady  = 1'b0;
        oValid  = 1'b0;
        oBusy   = 1'b0;
        oResult = 3'b000;
        oErr    = 1'b0;
        oCmpA   = 4'h0;
        oCmpB   = 4'h0;
        oCmpCas = CAS_EQ;

        unique case (state_q)
            IDLE: begin
                oReady = 1'b1;
                if (iValid) begin
                    opa_d   = iOpA;
                    opb_d   = iOpB;
                    idx_d   = '0;
                    cas_d   = CAS_EQ;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                oBusy   = 1'b1;
                oCmpA   = opa_q[idx_q*4 +: 4];
                oCmpB   = opb_q[idx_q*4 +: 4];
                oCmpCas = cas_q;
                // A malformed code restarts the cascade as "equal" so later nibbles still run.
                if ($onehot(iCmpRes)) begin
                    cas_d = iCmpRes;
                end else begin
                    cas_d = CAS_EQ;
                    err_d = 1'b1;
                end
                if (idx_q == IW'(NIB - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                oValid  = 1'b1;
                oResult = err_q ? 3'b000 : cas_q;
                oErr    = err_q;
                if (iReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmp_seq16.sv
// Scoreboard bench for cmp_seq16 with a behavioural cascaded 4-bit comparator
// that can be told to return a malformed code at a chosen nibble.
module tb_cmp_seq16;

    localparam int NIB = 4;

    logic             iClk;
    logic             iRst_n;
    logic             iValid;
    logic             oReady;
    logic [4*NIB-1:0] iOpA;
    logic [4*NIB-1:0] iOpB;
    logic             oValid;
    logic             iReady;
    logic [2:0]       oResult;
    logic             oErr;
    logic [3:0]       oCmpA;
    logic [3:0]       oCmpB;
    logic [2:0]       oCmpCas;
    logic [2:0]       iCmpRes;
    logic             oBusy;

    int n_chk = 0;
    int n_err = 0;
    int busy_cnt;
    int force_idx = -1;
    logic [3:0] sb[$];

    cmp_seq16 #(.NIB(NIB)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iValid  (iValid),
        .oReady  (oReady),
        .iOpA    (iOpA),
        .iOpB    (iOpB),
        .oValid  (oValid),
        .iReady  (iReady),
        .oResult (oResult),
        .oErr    (oErr),
        .oCmpA   (oCmpA),
        .oCmpB   (oCmpB),
        .oCmpCas (oCmpCas),
        .iCmpRes (iCmpRes),
        .oBusy   (oBusy)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // External 4-bit comparator: a decided nibble overrides the incoming cascade.
    function automatic logic [2:0] cmp4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] cas);
        if (a > b)      return 3'b100;
        else if (a < b) return 3'b010;
        else            return cas;
    endfunction

    // Counts cycles spent busy, which equals the nibble index while in RUN.
    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)    busy_cnt <= 0;
        else if (oBusy) busy_cnt <= busy_cnt + 1;
        else            busy_cnt <= 0;
    end

    always_comb begin
        iCmpRes = cmp4(oCmpA, oCmpB, oCmpCas);
        if (oBusy && (busy_cnt == force_idx)) iCmpRes = 3'b011;
    end

    function automatic logic [3:0] expect_of(input logic [15:0] a, input logic [15:0] b, input bit forced);
        if (forced)     return 4'b000_1;
        else if (a > b) return 4'b100_0;
        else if (a < b) return 4'b010_0;
        else            return 4'b001_0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, oReady, 1);
        chk({tag, "_valid"}, oValid, 0);
        chk({tag, "_busy"}, oBusy, 0);
        chk({tag, "_result"}, oResult, 0);
        chk({tag, "_err"}, oErr, 0);
        chk({tag, "_cmpa"}, oCmpA, 0);
        chk({tag, "_cmpb"}, oCmpB, 0);
        chk({tag, "_cas"}, oCmpCas, 3'b001);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit forced,
                          input int hold, input bit wiggle);
        int lat;
        bit seen;
        logic [3:0] r;
        sb.push_back(expect_of(a, b, forced));
        force_idx = forced ? 1 : -1;
        @(posedge iClk); #1;
        iOpA = a; iOpB = b; iValid = 1'b1; iReady = (hold == 0);
        lat = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge iClk); lat++; #1;
            if (lat == 1) iValid = wiggle;
            if (wiggle) begin
                iOpA = ~iOpA;
                iOpB = iOpB ^ 16'h5A5A;
            end
            @(negedge iClk);
            chk("excl", $onehot0({oReady, oValid, oBusy}), 1);
            if (oValid) seen = 1;
            else if (!oBusy) begin
                chk("idle_cmpa", oCmpA, 0);
                chk("idle_cas", oCmpCas, 3'b001);
            end
        end
        if (!seen) begin
            chk("timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            // Edges counted from the first edge that sees iValid high (the accept edge).
            chk("latency", lat, NIB + 1);
            r = sb.pop_front();
            chk("result", oResult, r[3:1]);
            chk("err", oErr, r[0]);
            chk("ready_in_done", oReady, 0);
            for (int h = 0; h < hold; h++) begin
                @(posedge iClk); #1;
                if (wiggle) iOpA = ~iOpA;
                @(negedge iClk);
                chk("hold_result", oResult, r[3:1]);
                chk("hold_err", oErr, r[0]);
                chk("hold_valid", oValid, 1);
                chk("hold_ready", oReady, 0);
            end
            iValid = 1'b0;
            iReady = 1'b1;
            @(posedge iClk);
            @(negedge iClk);
            chk("back_idle_ready", oReady, 1);
            chk("back_idle_valid", oValid, 0);
        end
        force_idx = -1;
    endtask

    initial begin
        iRst_n = 1'b0; iValid = 1'b0; iReady = 1'b1; iOpA = '0; iOpB = '0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        chk_reset_outputs("reset");
        iRst_n = 1'b1;

        run_op(16'h1234, 16'h1235, 0, 0, 0);
        run_op(16'hABCD, 16'hABCD, 0, 0, 0);
        run_op(16'h8000, 16'h7FFF, 0, 0, 0);
        run_op(16'h00F0, 16'h0F00, 0, 3, 1);

        // Abort an operation at nibble index 2.
        @(posedge iClk); #1;
        iOpA = 16'h1234; iOpB = 16'h0001; iValid = 1'b1; iReady = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iClk);
            if (oBusy && busy_cnt == 2) break;
        end
        chk("reached_idx2", oBusy && (busy_cnt == 2), 1);
        #1 iRst_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        @(negedge iClk);
        iRst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge iClk);
            chk("no_result_after_abort", oValid, 0);
        end
        run_op(16'h0001, 16'h0000, 0, 0, 0);

        run_op(16'h1234, 16'h1234, 1, 0, 0);
        run_op(16'h0005, 16'h0003, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? ra : 16'($urandom);
            run_op(ra, rb, 0, i % 2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
